// File: rtl/dmem_responder.sv
// Data-memory responder: one serialized access at a time to a word-addressed single-port RAM.
// Response LATENCY edges after acceptance; d_ready stays low from acceptance until the FSM is back in IDLE.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  output logic              d_ready,
  output logic              d_valid,
  output logic              d_err,
  output logic [DATA_W-1:0] d_datain
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                accept, access;
  logic [3:0]          cnt;
  logic                we_q, err_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic [ADDR_W-1:0]   idx;

  assign in_range = (addr_q[31:ADDR_W] == '0);
  assign idx      = addr_q[ADDR_W-1:0];

  assign d_ready  = (state == IDLE) && enable;
  assign d_valid  = (state == RESP);
  assign d_err    = d_valid && err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: if (d_req && enable) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (enable && cnt == '0) begin
        access    = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; the CPU may change its bus afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      d_datain <= '0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_dataout;
      end else if (state == WAIT && enable && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= !in_range;
        if (!we_q) d_datain <= in_range ? mem[idx] : '0;
      end
    end
  end

  // RAM contents survive reset; a reset while in WAIT keeps the FSM out of the access edge.
  always_ff @(posedge clock) begin
    if (access && we_q && in_range) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table vectors, randomized traffic against a memory model,
// and hand sequences for held requests, enable stalls, mid-access reset and LATENCY=1.
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en   [2];
  logic        req  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        vld  [2];
  logic        err  [2];

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT0)) u_dut0 (
    .clock(clock), .reset(reset), .enable(en[0]), .d_req(req[0]), .d_we(we[0]),
    .d_addr(addr[0]), .d_dataout(wdat[0]), .d_ready(rdy[0]), .d_valid(vld[0]),
    .d_err(err[0]), .d_datain(rdat[0]));

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT1)) u_dut1 (
    .clock(clock), .reset(reset), .enable(en[1]), .d_req(req[1]), .d_we(we[1]),
    .d_addr(addr[1]), .d_dataout(wdat[1]), .d_ready(rdy[1]), .d_valid(vld[1]),
    .d_err(err[1]), .d_datain(rdat[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a plain array per DUT plus the value d_datain should be holding.
  logic [31:0] mdl_mem   [2][1024];
  bit          mdl_known [2][1024];
  logic [31:0] mdl_last  [2];
  bit          mdl_last_known [2];

  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       output bit e, output logic [31:0] r, output bit known);
    if (a >= 32'd1024) begin
      e = 1'b1;
      if (!w) begin
        mdl_last[s]       = 32'h0;
        mdl_last_known[s] = 1'b1;
      end
    end else begin
      e = 1'b0;
      if (w) begin
        mdl_mem[s][a]   = wd;
        mdl_known[s][a] = 1'b1;
      end else begin
        mdl_last[s]       = mdl_mem[s][a];
        mdl_last_known[s] = mdl_known[s][a];
      end
    end
    r     = mdl_last[s];
    known = mdl_last_known[s];
  endtask

  // Issue one request at a negedge; lat = edges from acceptance to the cycle d_valid is seen.
  task automatic run_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input int hold_off, output int lat, output bit e,
                         output logic [31:0] r, output bit stray);
    int k;
    stray = 1'b0;
    @(negedge clock);
    k = 0;
    while (!rdy[s] && k < 20) begin
      @(negedge clock);
      k++;
    end
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdat[s] = wd;
    for (lat = 0; lat <= 40; lat++) begin
      @(negedge clock);
      if (lat == 0) begin
        req[s] = 1'b0; we[s] = 1'($urandom); addr[s] = $urandom; wdat[s] = $urandom;
      end
      if (vld[s]) break;
      if (err[s] || rdy[s]) stray = 1'b1;
      en[s] = (lat >= hold_off);
    end
    e = err[s];
    r = rdat[s];
    en[s] = 1'b1;
  endtask

  task automatic do_chk(input int s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input int hold_off, input string tag);
    bit          xe, xk, ge, st;
    logic [31:0] xr, gr;
    int          lat;
    model(s, w, a, wd, xe, xr, xk);
    run_txn(s, w, a, wd, hold_off, lat, ge, gr, st);
    check({tag, " lat"}, lat, ((s == 0) ? LAT0 : LAT1) + hold_off);
    check({tag, " err"}, {31'b0, ge}, {31'b0, xe});
    check({tag, " ready/err while busy"}, {31'b0, st}, 32'h0);
    if (xk) check({tag, " data"}, gr, xr);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          xe, xk, ge, st;
    logic [31:0] xr, gr;
    int          lat, p;

    for (int s = 0; s < 2; s++) begin
      en[s] = 1'b1; req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
      mdl_last[s] = 32'h0; mdl_last_known[s] = 1'b1;
      for (int i = 0; i < 1024; i++) mdl_known[s][i] = 1'b0;
    end

    vt[0] = '{1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'h00000000};
    vt[1] = '{1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF};
    vt[2] = '{1'b1, 32'd0,         32'h0000A5A5, 1'b0, 32'hDEADBEEF};
    vt[3] = '{1'b0, 32'h400,       32'h0,        1'b1, 32'h00000000};
    vt[4] = '{1'b1, 32'h400,       32'hFFFFFFFF, 1'b1, 32'h00000000};
    vt[5] = '{1'b0, 32'd0,         32'h0,        1'b0, 32'h0000A5A5};
    vt[6] = '{1'b1, 32'h3FF,       32'h13579BDF, 1'b0, 32'h0000A5A5};
    vt[7] = '{1'b0, 32'h3FF,       32'h0,        1'b0, 32'h13579BDF};
    vt[8] = '{1'b0, 32'h80000005,  32'h0,        1'b1, 32'h00000000};
    vt[9] = '{1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF};

    // Reset state
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d valid", s), {31'b0, vld[s]}, 32'h0);
      check($sformatf("reset%0d err", s),   {31'b0, err[s]}, 32'h0);
      check($sformatf("reset%0d datain", s), rdat[s], 32'h0);
    end
    reset = 1'b1;
    @(negedge clock);
    for (int s = 0; s < 2; s++) check($sformatf("reset%0d ready", s), {31'b0, rdy[s]}, 32'h1);

    // Table vectors, expectations written out by hand
    for (int i = 0; i < 10; i++) begin
      model(0, vt[i].w, vt[i].a, vt[i].wd, xe, xr, xk);
      run_txn(0, vt[i].w, vt[i].a, vt[i].wd, 0, lat, ge, gr, st);
      check($sformatf("vec%0d lat", i), lat, LAT0);
      check($sformatf("vec%0d err", i), {31'b0, ge}, {31'b0, vt[i].exp_err});
      check($sformatf("vec%0d data", i), gr, vt[i].exp_rd);
      check($sformatf("vec%0d busy", i), {31'b0, st}, 32'h0);
    end

    // Held request: accept, LATENCY wait edges, one RESP cycle, one IDLE cycle
    p = LAT0 + 2;
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd5;
    for (int i = 0; i < 3 * p; i++) begin
      check($sformatf("held c%0d ready", i), {31'b0, rdy[0]}, {31'b0, (i % p) == 0});
      check($sformatf("held c%0d valid", i), {31'b0, vld[0]}, {31'b0, (i % p) == p - 1});
      if (vld[0]) check($sformatf("held c%0d data", i), rdat[0], 32'hDEADBEEF);
      @(negedge clock);
    end
    req[0] = 1'b0;
    model(0, 1'b0, 32'd5, 32'h0, xe, xr, xk);

    // Enable low for 3 cycles during WAIT
    do_chk(0, 1'b1, 32'd9, 32'h55AA55AA, 3, "stall write");
    do_chk(0, 1'b0, 32'd9, 32'h0,        3, "stall read");

    // Reset during WAIT of a write: old contents must survive
    do_chk(0, 1'b1, 32'd7, 32'h0000CAFE, 0, "pre-reset write");
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd7; wdat[0] = 32'h00001234;
    @(negedge clock);
    req[0] = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("mid reset valid", {31'b0, vld[0]}, 32'h0);
    check("mid reset datain", rdat[0], 32'h0);
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      mdl_last[s] = 32'h0; mdl_last_known[s] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("post reset c%0d valid", i), {31'b0, vld[0]}, 32'h0);
      check($sformatf("post reset c%0d ready", i), {31'b0, rdy[0]}, 32'h1);
    end
    do_chk(0, 1'b0, 32'd7, 32'h0, 0, "post reset read");

    // LATENCY=1 instance: back-to-back accesses, read data held across a write
    do_chk(1, 1'b1, 32'd3, 32'h00000111, 0, "l1 write3");
    do_chk(1, 1'b0, 32'd3, 32'h0,        0, "l1 read3");
    do_chk(1, 1'b1, 32'd4, 32'h00000222, 0, "l1 write4");
    @(negedge clock);
    check("l1 idle hold", rdat[1], 32'h00000111);
    do_chk(1, 1'b0, 32'd4, 32'h0,        0, "l1 read4");
    do_chk(1, 1'b0, 32'h00000400, 32'h0, 0, "l1 oor read");

    // Randomized traffic on a small address window with occasional out-of-range and stalls
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      int          ho;
      ra = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h00000400) : $urandom_range(0, 31);
      ho = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      do_chk(i % 2, 1'($urandom), ra, $urandom, ho, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
